// File: rtl/mips_pkg.sv
// Shared definitions for the single-cycle core front end: fetch FSM states,
// default reset vector and instruction field widths.
package mips_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam int unsigned IMM_W  = 16;
  localparam int unsigned JIDX_W = 26;

  // Clears the byte-offset bits so every PC load stays word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/next_pc_mux.sv
// Next-PC selection for the retiring instruction: jump beats taken branch,
// which beats sequential fall-through. Purely combinational.
module next_pc_mux
  import mips_pkg::*;
(
  input  logic [31:0]       pc_plus4,
  input  logic [31:0]       imm_ext,
  input  logic [JIDX_W-1:0] jump_index,
  input  logic              branch_taken,
  input  logic              jump,
  output logic [31:0]       next_pc
);

  logic [31:0] branch_target;
  logic [31:0] jump_target;

  // Word offset: the two top immediate bits fall off the shift.
  assign branch_target = pc_plus4 + (imm_ext << 2);
  assign jump_target   = {pc_plus4[31:28], jump_index, 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = jump_target;
    end else if (branch_taken) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Program counter and instruction register for the single-cycle core:
// fetches one word over a req/ready handshake, holds it until retire.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_plus4,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [31:0]       imm_ext,
  input  logic              jump,
  input  logic [JIDX_W-1:0] jump_index,
  output logic [31:0]       retired_count
);

  fetch_state_e state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic              valid_q, valid_d;
  logic [31:0]       retired_q, retired_d;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] next_pc;

  assign pc_inc = pc_q + 32'd4;

  next_pc_mux u_next_pc_mux (
    .pc_plus4     (pc_inc),
    .imm_ext      (imm_ext),
    .jump_index   (jump_index),
    .branch_taken (branch_taken),
    .jump         (jump),
    .next_pc      (next_pc)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    retired_d = retired_q;
    unique case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!stall) begin
          pc_d      = word_align(next_pc);
          valid_d   = 1'b0;
          retired_d = retired_q + 32'd1;
          state_d   = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= word_align(RESET_PC);
      instr_q   <= '0;
      valid_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      retired_q <= retired_d;
    end
  end

  // Every output below is a pure function of registered state.
  assign imem_req      = (state_q == S_FETCH);
  assign imem_addr     = pc_q;
  assign instr         = instr_q;
  assign instr_valid   = valid_q;
  assign pc_out        = pc_q;
  assign pc_plus4      = pc_inc;
  assign retired_count = retired_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Owns the program counter and the instruction register for the single-cycle core. Fetches one instruction at a time from instruction memory over a req/ready handshake.
- Holds the fetched instruction for decode. Decode slices the 16-bit immediate and sends it to the sign extender.
- Consumes the 32-bit sign-extended immediate to form the branch target, plus the jump index. Selects and registers the next PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.
- ADDR_W, 32, PC/address width; only 32 supported.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address, equal to pc.
- imem_ready  in  1  memory has valid data on imem_rdata this cycle.
- imem_rdata  in  32  fetched instruction word.
- instr  out  32  held instruction, sent to decode.
- instr_valid  out  1  instr is valid and awaiting execution.
- pc_out  out  32  address of the held instruction.
- pc_plus4  out  32  pc_out + 4.
- stall  in  1  core not ready to retire the held instruction.
- branch_taken  in  1  held instruction is a taken branch; sampled on retire.
- imm_ext  in  32  sign-extended immediate of the held instruction.
- jump  in  1  held instruction is J/JAL; sampled on retire.
- jump_index  in  26  instr[25:0] of the held instruction.
- retired_count  out  32  wrapping count of retired instructions.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values (rst_n=0 at a clk edge):
  - state=S_IDLE, pc=RESET_PC, instr=32'h0, instr_valid=0, retired_count=0.
  - imem_req=0.
  - Reset overrides everything, including an in-flight fetch; any imem_ready in that cycle is ignored.
- FSM, three states:
  - S_IDLE: imem_req=0. Unconditionally goes to S_FETCH on the next cycle. This gives one dead cycle after reset.
  - S_FETCH: imem_req=1, imem_addr=pc.
    - When imem_ready=1: instr<=imem_rdata, instr_valid<=1, go to S_EXEC.
    - Otherwise stay; imem_addr stays stable.
    - Wait states are unbounded.
  - S_EXEC: instr_valid=1, imem_req=0.
    - Retire condition: stall=0. On retire: pc<=next_pc, instr_valid<=0, retired_count<=retired_count+1 (wraps 0xFFFF_FFFF -> 0), go to S_FETCH.
    - If stall=1: hold instr, pc and counter unchanged.
- Minimum latency: fetch request to instr_valid is 1 cycle with zero wait states. Retire to next imem_req is 1 cycle.
- imem_req, imem_addr, instr_valid, pc_out and pc_plus4 are decoded/derived from registers only. They have no combinational path from inputs.
- next_pc selection, combinational, evaluated only in the retire cycle. Priority order:
  - jump=1: {pc_plus4[31:28], jump_index, 2'b00}.
  - else branch_taken=1: pc_plus4 + {imm_ext[29:0], 2'b00}.
  - else: pc_plus4.
- Both jump and branch_taken set: jump wins.
- branch_taken, jump, imm_ext and jump_index are don't-care outside the retire cycle.
- Arithmetic: all adds are 32-bit modulo 2^32. PC wrap 0xFFFF_FFFC + 4 = 0x0000_0000 is legal.
- Alignment: pc[1:0] is forced to 2'b00 on every load. imem_addr[1:0] is always 00.

Decomposition:
- Shared package mips_pkg holds:
  - FSM state encoding (S_IDLE, S_FETCH, S_EXEC).
  - Default RESET_PC constant.
  - Instruction field widths: IMM_W=16, JIDX_W=26.
- Sub-module next_pc_mux: purely combinational. Inputs pc_plus4, imm_ext, jump_index, branch_taken, jump. Output next_pc.

Test Plan:
- Reset then sequential fetch: RESET_PC=0, imem_ready=1 always, stall=0.
  - imem_req=0 for 1 cycle after reset.
  - imem_addr then steps 0x0, 0x4, 0x8.
  - retired_count=3 after three retires.
- Branch backward: pc=0x0000_0010, imm_ext=0xFFFF_FFFC, branch_taken=1 on retire -> next imem_addr=0x0000_0004.
- Jump beats branch: pc=0x1000_0008, jump=1, branch_taken=1, jump_index=26'h0000040, imm_ext=0x10 -> next imem_addr=0x1000_0100.
- Wait states and stall:
  - imem_ready low for 3 cycles -> imem_req held high, imem_addr stable, instr_valid=0.
  - Then stall=1 for 2 cycles -> instr, pc_out and retired_count unchanged. Retire on the cycle stall drops.
- Reset mid-fetch: rst_n=0 while in S_FETCH with imem_ready=1 -> instr_valid=0, pc=RESET_PC, and the rdata is not captured.
- Counter wrap: force retired_count to 0xFFFF_FFFF, retire once -> 0x0000_0000.
